// File: rtl/urv_dm_responder.sv
// Data-memory responder: serves core loads/stores from a local RAM window
// or forwards them as single accesses on a classic external bus with timeout.
module urv_dm_responder #(
  parameter int unsigned g_ram_size_log2 = 16,
  parameter logic [31:0] g_ram_base      = 32'h0000_0000,
  parameter int unsigned g_timeout       = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [31:0]                  dm_addr_i,
  input  logic [31:0]                  dm_data_s_i,
  input  logic [3:0]                   dm_data_select_i,
  input  logic                         dm_load_i,
  input  logic                         dm_store_i,
  output logic [31:0]                  dm_data_l_o,
  output logic                         dm_load_done_o,
  output logic                         dm_store_done_o,
  output logic                         dm_error_o,
  output logic [g_ram_size_log2-3:0]   ram_addr_o,
  output logic [31:0]                  ram_wdata_o,
  output logic [3:0]                   ram_we_o,
  output logic                         ram_re_o,
  input  logic [31:0]                  ram_rdata_i,
  output logic                         ext_cyc_o,
  output logic                         ext_stb_o,
  output logic                         ext_we_o,
  output logic [3:0]                   ext_sel_o,
  output logic [31:0]                  ext_adr_o,
  output logic [31:0]                  ext_dat_o,
  input  logic [31:0]                  ext_dat_i,
  input  logic                         ext_ack_i,
  input  logic                         ext_err_i
);

  // state  | meaning
  // IDLE   | accepting requests; RAM stores complete without leaving IDLE
  // RAM_LD | RAM read data valid this cycle, load completes
  // EXT    | external access in flight, waiting for ack/err/timeout
  typedef enum logic [1:0] {ST_IDLE, ST_RAM_LD, ST_EXT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tmo;
  logic [31:0] r_data_l;
  logic        r_load_done;
  logic        r_store_done;
  logic        r_error;
  logic [31:0] r_ext_adr;
  logic [31:0] r_ext_dat;
  logic [3:0]  r_ext_sel;
  logic        r_ext_we;

  logic        w_ram_hit;
  logic        w_st_req;
  logic        w_ld_req;
  logic        w_idle;
  logic        w_ram_st;
  logic        w_ram_ld;
  logic        w_ext_go;
  logic        w_in_ext;
  logic        w_in_ram_ld;
  logic [15:0] w_tmo_nxt;
  logic        w_tmo_hit;
  logic        w_ext_ok;
  logic        w_ext_end;

  assign w_ram_hit   = (dm_addr_i[31:g_ram_size_log2] == g_ram_base[31:g_ram_size_log2]);
  // a simultaneous load+store strobe is served as a store
  assign w_st_req    = dm_store_i;
  assign w_ld_req    = dm_load_i & ~dm_store_i;
  assign w_idle      = (r_state == ST_IDLE) & ~rst_i;
  assign w_ram_st    = w_idle & w_st_req & w_ram_hit;
  assign w_ram_ld    = w_idle & w_ld_req & w_ram_hit;
  assign w_ext_go    = w_idle & (w_st_req | w_ld_req) & ~w_ram_hit;
  assign w_in_ext    = (r_state == ST_EXT);
  assign w_in_ram_ld = (r_state == ST_RAM_LD);

  assign w_tmo_nxt   = r_tmo + 16'd1;
  assign w_tmo_hit   = (w_tmo_nxt == 16'(g_timeout));
  assign w_ext_ok    = w_in_ext & ext_ack_i & ~ext_err_i;
  assign w_ext_end   = w_in_ext & (ext_ack_i | ext_err_i | w_tmo_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ram_ld)      w_state_nxt = ST_RAM_LD;
        else if (w_ext_go) w_state_nxt = ST_EXT;
      end
      ST_RAM_LD: w_state_nxt = ST_IDLE;
      ST_EXT:    if (w_ext_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo        <= 16'd0;
      r_data_l     <= 32'd0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_error      <= 1'b0;
      r_ext_adr    <= 32'd0;
      r_ext_dat    <= 32'd0;
      r_ext_sel    <= 4'd0;
      r_ext_we     <= 1'b0;
    end else begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_error      <= 1'b0;
      if (w_ram_st) r_store_done <= 1'b1;
      if (w_in_ram_ld) r_data_l <= ram_rdata_i;
      if (w_ext_go) begin
        r_ext_adr <= dm_addr_i;
        r_ext_dat <= dm_data_s_i;
        r_ext_sel <= dm_data_select_i;
        r_ext_we  <= w_st_req;
        r_tmo     <= 16'd0;
      end else if (w_in_ext) begin
        r_tmo <= w_tmo_nxt;
      end
      // error and timeout both terminate with zero load data
      if (w_ext_end) begin
        r_load_done  <= ~r_ext_we;
        r_store_done <= r_ext_we;
        r_error      <= ~w_ext_ok;
        if (!r_ext_we) r_data_l <= w_ext_ok ? ext_dat_i : 32'd0;
      end
    end
  end

  assign dm_data_l_o     = w_in_ram_ld ? ram_rdata_i : r_data_l;
  assign dm_load_done_o  = r_load_done | (w_in_ram_ld & ~rst_i);
  assign dm_store_done_o = r_store_done;
  assign dm_error_o      = r_error;

  assign ram_addr_o      = dm_addr_i[g_ram_size_log2-1:2];
  assign ram_wdata_o     = dm_data_s_i;
  assign ram_we_o        = w_ram_st ? dm_data_select_i : 4'b0000;
  assign ram_re_o        = w_ram_ld;

  assign ext_cyc_o       = w_in_ext;
  assign ext_stb_o       = w_in_ext;
  assign ext_we_o        = r_ext_we;
  assign ext_sel_o       = r_ext_sel;
  assign ext_adr_o       = r_ext_adr;
  assign ext_dat_o       = r_ext_dat;

endmodule

// File: tb/tb_urv_dm_responder.sv
// Scoreboard bench for urv_dm_responder: driver pushes expected completions,
// a combined bus-slave/monitor process answers the external bus and checks.
`timescale 1ns/1ps
module tb_urv_dm_responder;
  localparam int LP_TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_error_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_we_o;
  logic        ram_re_o;
  logic [31:0] ram_rdata_i;
  logic        ext_cyc_o;
  logic        ext_stb_o;
  logic        ext_we_o;
  logic [3:0]  ext_sel_o;
  logic [31:0] ext_adr_o;
  logic [31:0] ext_dat_o;
  logic [31:0] ext_dat_i;
  logic        ext_ack_i;
  logic        ext_err_i;

  always #5 clk_i = ~clk_i;

  urv_dm_responder #(
    .g_ram_size_log2(16),
    .g_ram_base(32'h0000_0000),
    .g_timeout(LP_TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o), .dm_error_o(dm_error_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .ram_re_o(ram_re_o), .ram_rdata_i(ram_rdata_i),
    .ext_cyc_o(ext_cyc_o), .ext_stb_o(ext_stb_o), .ext_we_o(ext_we_o),
    .ext_sel_o(ext_sel_o), .ext_adr_o(ext_adr_o), .ext_dat_o(ext_dat_o),
    .ext_dat_i(ext_dat_i), .ext_ack_i(ext_ack_i), .ext_err_i(ext_err_i)
  );

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  bit   [31:0] ram_mem [16384];
  bit   [31:0] ref_mem [16384];
  logic [31:0] last_load = 32'd0;

  // external-bus plan: mode 0 none, 1 ack, 2 err, 3 err+ack; lat = strobe cycle that answers
  int          p_mode = 0;
  int          p_lat = 0;
  logic [31:0] p_adr = 32'd0, p_dat = 32'd0, p_sdat = 32'd0;
  logic [3:0]  p_sel = 4'd0;
  logic        p_we = 1'b0;
  bit          force_ack = 1'b0;
  int          cyc_cnt = 0;
  int          last_len = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (ram_re_o) ram_rdata_i <= ram_mem[ram_addr_o];
    if (ram_we_o != 4'b0000) ram_mem[ram_addr_o] <= merge(ram_mem[ram_addr_o], ram_wdata_o, ram_we_o);
  end

  always begin
    @(posedge clk_i); #1;
    ext_ack_i = force_ack;
    ext_err_i = 1'b0;
    ext_dat_i = $urandom;
    if (ext_cyc_o) begin
      cyc_cnt++;
      chk("ext_stb", 32'(ext_stb_o), 32'd1);
      chk("ext_adr", ext_adr_o, p_adr);
      chk("ext_sel", 32'(ext_sel_o), 32'(p_sel));
      chk("ext_we", 32'(ext_we_o), 32'(p_we));
      if (p_we) chk("ext_dat", ext_dat_o, p_sdat);
      if (cyc_cnt == p_lat) begin
        case (p_mode)
          1: begin ext_ack_i = 1'b1; ext_dat_i = p_dat; end
          2: ext_err_i = 1'b1;
          3: begin ext_err_i = 1'b1; ext_ack_i = 1'b1; ext_dat_i = p_dat; end
          default: ;
        endcase
      end
    end else begin
      if (cyc_cnt != 0) last_len = cyc_cnt;
      cyc_cnt = 0;
      chk("ext_stb_idle", 32'(ext_stb_o), 32'd0);
    end

    @(negedge clk_i);
    if (rst_i) last_load = 32'd0;
    if (dm_load_done_o || dm_store_done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: load_done=%0b store_done=%0b with nothing outstanding",
                 dm_load_done_o, dm_store_done_o);
      end else begin
        mon_e = sb.pop_front();
        chk("done_kind", 32'({dm_load_done_o, dm_store_done_o}), 32'({mon_e.is_load, !mon_e.is_load}));
        chk("error", 32'(dm_error_o), 32'(mon_e.err));
        if (mon_e.is_load) begin
          chk("load_data", dm_data_l_o, mon_e.data);
          last_load = mon_e.data;
        end else begin
          chk("data_hold", dm_data_l_o, last_load);
        end
      end
    end else if (dm_error_o) begin
      checks++;
      errors++;
      $display("FAIL error_without_done: dm_error_o=1 but no done pulse");
    end
  end

  task automatic do_req(input bit ld, input bit st, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input bit inject);
    bit          hit;
    logic [13:0] wr;
    exp_t        e;
    int          exp_len;
    hit = (adr[31:16] == 16'h0);
    wr  = adr[15:2];
    exp_len = 0;
    @(posedge clk_i); #1;
    dm_addr_i = adr; dm_data_s_i = dat; dm_data_select_i = sel;
    dm_load_i = ld; dm_store_i = st;
    if (!hit) begin
      p_adr = adr; p_we = st; p_sel = sel; p_sdat = dat;
    end
    #1;
    if (hit && st) begin
      chk("ram_we", 32'(ram_we_o), 32'(sel));
      chk("ram_addr", 32'(ram_addr_o), 32'(wr));
      chk("ram_wdata", ram_wdata_o, dat);
      chk("ram_re_on_store", 32'(ram_re_o), 32'd0);
      ref_mem[wr] = merge(ref_mem[wr], dat, sel);
      e.is_load = 1'b0; e.data = 32'd0; e.err = 1'b0;
    end else if (hit) begin
      chk("ram_re", 32'(ram_re_o), 32'd1);
      chk("ram_addr_ld", 32'(ram_addr_o), 32'(wr));
      chk("ram_we_on_load", 32'(ram_we_o), 32'd0);
      e.is_load = 1'b1; e.data = ref_mem[wr]; e.err = 1'b0;
    end else begin
      chk("ext_no_ram_we", 32'(ram_we_o), 32'd0);
      chk("ext_no_ram_re", 32'(ram_re_o), 32'd0);
      e.is_load = !st;
      if (p_mode != 0 && p_lat <= LP_TMO) begin
        e.err = (p_mode != 1);
        e.data = (p_mode == 1) ? p_dat : 32'd0;
        exp_len = p_lat;
      end else begin
        e.err = 1'b1;
        e.data = 32'd0;
        exp_len = LP_TMO;
      end
    end
    sb.push_back(e);
    @(posedge clk_i); #1;
    dm_load_i = 1'b0; dm_store_i = 1'b0;
    if (inject && !(hit && st)) begin
      dm_addr_i = 32'h0000_0040; dm_data_select_i = 4'hF;
      dm_store_i = 1'b1; dm_load_i = 1'($urandom_range(0, 1));
      #1;
      chk("ignored_we", 32'(ram_we_o), 32'd0);
      chk("ignored_re", 32'(ram_re_o), 32'd0);
      @(posedge clk_i); #1;
      dm_store_i = 1'b0; dm_load_i = 1'b0;
    end
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk_i);
    if (sb.size() != 0) begin
      chk("completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    if (!hit) chk("cyc_len", 32'(last_len), 32'(exp_len));
  endtask

  task automatic set_plan(input int mode, input int lat, input logic [31:0] d);
    p_mode = mode; p_lat = lat; p_dat = d;
  endtask

  initial begin
    rst_i = 1'b1;
    dm_addr_i = 32'h0000_0104; dm_data_s_i = 32'hFFFF_FFFF; dm_data_select_i = 4'hF;
    dm_load_i = 1'b0; dm_store_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_ram_we", 32'(ram_we_o), 32'd0);
    chk("rst_ram_re", 32'(ram_re_o), 32'd0);
    chk("rst_data_l", dm_data_l_o, 32'd0);
    chk("rst_cyc", 32'(ext_cyc_o), 32'd0);
    chk("rst_ext_we", 32'(ext_we_o), 32'd0);
    chk("rst_dones", 32'({dm_load_done_o, dm_store_done_o, dm_error_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; dm_store_i = 1'b0;

    do_req(0, 1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 0);
    do_req(0, 1, 32'h0000_0104, 32'h1234_5678, 4'b1111, 0);
    do_req(1, 0, 32'h0000_0104, 32'h0, 4'hF, 0);

    set_plan(1, 3, 32'hCAFE_F00D);
    do_req(1, 0, 32'h8000_0010, 32'h0, 4'hF, 0);
    set_plan(0, 0, 32'h0);
    do_req(0, 1, 32'h9000_0020, 32'h5555_AAAA, 4'b0101, 0);
    set_plan(3, 2, 32'h7777_1111);
    do_req(1, 0, 32'h8000_0030, 32'h0, 4'hF, 0);
    set_plan(1, LP_TMO, 32'hA5A5_0001);
    do_req(1, 0, 32'h8000_0044, 32'h0, 4'hF, 0);
    set_plan(1, LP_TMO + 1, 32'hA5A5_0002);
    do_req(1, 0, 32'h8000_0048, 32'h0, 4'hF, 0);
    do_req(1, 1, 32'h0000_0010, 32'h0BAD_F00D, 4'b1100, 0);
    do_req(1, 0, 32'h0000_0010, 32'h0, 4'hF, 1);
    set_plan(1, 4, 32'h0102_0304);
    do_req(1, 0, 32'h8000_0050, 32'h0, 4'hF, 1);

    set_plan(0, 0, 32'h0);
    p_adr = 32'h8000_0060; p_we = 1'b0; p_sel = 4'hF;
    @(posedge clk_i); #1;
    dm_addr_i = p_adr; dm_data_select_i = 4'hF; dm_load_i = 1'b1;
    @(posedge clk_i); #1;
    dm_load_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_ext_cyc", 32'(ext_cyc_o), 32'd0);
    chk("rst_ext_data", dm_data_l_o, 32'd0);
    @(negedge clk_i); force_ack = 1'b1;
    repeat (2) @(negedge clk_i);
    force_ack = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("late_ack_cyc", 32'(ext_cyc_o), 32'd0);
    do_req(0, 1, 32'h0000_0200, 32'h600D_600D, 4'hF, 0);

    @(posedge clk_i); #1;
    dm_addr_i = 32'h0000_0200; dm_load_i = 1'b1;
    @(posedge clk_i); #1;
    dm_load_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_ld_data", dm_data_l_o, 32'd0);
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 80; i++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 5);
      if (k < 3) a = {16'h0, 14'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      else       a = {1'b1, 31'($urandom)};
      set_plan($urandom_range(0, 3), $urandom_range(1, 10), $urandom);
      case (k)
        0, 4:    do_req(0, 1, a, $urandom, 4'($urandom_range(1, 15)), 0);
        1, 3:    do_req(1, 0, a, $urandom, 4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
        default: do_req(1, 1, a, $urandom, 4'($urandom_range(1, 15)), 0);
      endcase
    end

    repeat (5) @(posedge clk_i);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/urv_dm_responder.md
URV_DM_RESPONDER -- requirements
Module: urv_dm_responder

Interface
REQ-001 Parameter g_ram_size_log2, default 16, byte-size log2 of local RAM window.
REQ-002 Parameter g_ram_base, default 32'h0000_0000, RAM window base; aligned to 2^g_ram_size_log2.
REQ-003 Parameter g_timeout, default 255, max external-bus wait cycles before error (1..65535).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 dm_addr_i  in  32  byte address from execute stage.
REQ-007 dm_data_s_i  in  32  store data, lane-replicated by core.
REQ-008 dm_data_select_i  in  4  byte-lane enables.
REQ-009 dm_load_i / dm_store_i  in  1 each  single-cycle request strobes.
REQ-010 dm_data_l_o  out  32  load data, valid with dm_load_done_o.
REQ-011 dm_load_done_o / dm_store_done_o  out  1 each  one-cycle completion pulses.
REQ-012 dm_error_o  out  1  one-cycle pulse coincident with a done pulse on bus error/timeout.
REQ-013 ram_addr_o  out  g_ram_size_log2-2  word address; ram_wdata_o out 32; ram_we_o out 4; ram_re_o out 1; ram_rdata_i in 32 (registered, 1-cycle latency).
REQ-014 ext_cyc_o, ext_stb_o, ext_we_o out 1; ext_sel_o out 4; ext_adr_o out 32; ext_dat_o out 32; ext_dat_i in 32; ext_ack_i, ext_err_i in 1 (classic single-access bus).

Function
REQ-015 Decode: RAM hit when dm_addr_i[31:g_ram_size_log2] == g_ram_base[31:g_ram_size_log2]; else external.
REQ-016 FSM states IDLE, RAM_LD, EXT; requests accepted only in IDLE.
REQ-017 RAM store in IDLE: ram_we_o = dm_data_select_i combinationally same cycle, ram_wdata_o = dm_data_s_i, ram_addr_o = dm_addr_i word bits; dm_store_done_o pulses next cycle; FSM stays IDLE (back-to-back stores allowed).
REQ-018 RAM load in IDLE: ram_re_o = 1 same cycle, -> RAM_LD; in RAM_LD dm_load_done_o = 1, dm_data_l_o = ram_rdata_i (full word, lane extraction by writeback), -> IDLE.
REQ-019 External request in IDLE: latch addr, data, sel, we; -> EXT; ext_cyc_o = ext_stb_o = 1 from next cycle until termination.
REQ-020 EXT termination: ext_ack_i -> done pulse next cycle, load data = ext_dat_i captured at ack; ext_err_i (priority over ack) -> done + dm_error_o next cycle, load data 32'h0.
REQ-021 Timeout counter 16-bit, cleared on entry to EXT, increments each EXT cycle; reaching g_timeout without ack/err -> drop cyc/stb, done + dm_error_o next cycle, data 32'h0.
REQ-022 ext_cyc_o/ext_stb_o deassert the cycle after termination; no second strobe for same request.
REQ-023 dm_load_i and dm_store_i both high: treated as store only.
REQ-024 Requests arriving in RAM_LD or EXT ignored: no RAM/bus access, no done pulse.
REQ-025 dm_data_l_o holds last value between loads; done/error outputs low otherwise.
REQ-026 ext_dat_o/ext_sel_o/ext_adr_o stable for whole EXT access.

Reset
REQ-027 rst_i high: FSM -> IDLE, timeout counter 0, dm_data_l_o 0, all done/error, ram_re_o, ram_we_o, ext_cyc_o, ext_stb_o, ext_we_o 0 at next edge.
REQ-028 Reset during EXT or RAM_LD: access abandoned, no done pulse ever issued for it; late ext_ack_i after reset ignored.
REQ-029 Combinational RAM strobes gated by rst_i (no write during reset cycle).

Verification
REQ-030 RAM store: addr 0x0000_0104, data 0xDEADBEEF, sel 4'b0011 -> same cycle ram_we_o=0011, ram_addr_o=0x41; next cycle dm_store_done_o=1, dm_error_o=0.
REQ-031 RAM load: addr 0x0000_0104, ram_rdata_i=0x12345678 -> ram_re_o same cycle, next cycle dm_load_done_o=1, dm_data_l_o=0x12345678.
REQ-032 External load: addr 0x8000_0010, ack after 3 cycles with ext_dat_i=0xCAFEF00D -> cyc/stb high 3 cycles, done next cycle with 0xCAFEF00D, error 0.
REQ-033 Timeout: g_timeout=8, external store, no ack -> cyc/stb drop after 8 cycles; dm_store_done_o and dm_error_o pulse together once.
REQ-034 Bus error + simultaneous ack on external load -> dm_load_done_o=1, dm_error_o=1, dm_data_l_o=0.
REQ-035 Reset asserted mid-EXT then ext_ack_i -> ext_cyc_o=0 after reset edge, no done pulse; next RAM store completes normally.
